// File: rtl/bit_serial_adder_ctrl.sv
// rtl/bit_serial_adder_ctrl.sv - bit-serial add/subtract sequencer with valid/ready handshakes
// One full-adder slice (two half adders + OR) is reused for WIDTH cycles, LSB first.
module bit_serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_overflow;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             r_busy;

  logic             w_ha1_s;
  logic             w_ha1_c;
  logic             w_ha2_c;
  logic             w_s;
  logic             w_cout;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  assign w_ha1_s    = r_a_sh[0] ^ r_b_sh[0];
  assign w_ha1_c    = r_a_sh[0] & r_b_sh[0];
  assign w_s        = w_ha1_s ^ r_carry;
  assign w_ha2_c    = w_ha1_s & r_carry;
  assign w_cout     = w_ha1_c | w_ha2_c;
  // Partial result holds WIDTH-1 bits; the final bit joins it on the last RUN cycle.
  assign w_res_next = {w_s, r_res};
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_c_out     <= 1'b0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh     <= a;
            r_b_sh     <= b ^ {WIDTH{sub}};
            r_carry    <= sub ? 1'b1 : c_in;
            r_cnt      <= '0;
            r_res      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_res   <= w_res_next[WIDTH-1:1];
          r_carry <= w_cout;
          if (w_last) begin
            // r_carry here is the carry into the MSB
            r_sum       <= w_res_next;
            r_c_out     <= w_cout;
            r_overflow  <= r_carry ^ w_cout;
            r_out_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// tb/tb_bit_serial_adder_ctrl.sv - self-checking bench for bit_serial_adder_ctrl
// Directed vector table, reset abort, backpressure and back-to-back random traffic against an arithmetic model.
module tb_bit_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  bit_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    logic         vs;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                          input logic tc, input logic ts);
    int unsigned full;
    int          sa;
    int          sb;
    int          sres;
    logic        ovf;
    logic [W-1:0] s8;
    logic         co;
    sa = int'($signed(ta));
    sb = int'($signed(tb));
    if (ts) begin
      full = int'(ta) + 256 - int'(tb);
      sres = sa - sb;
    end else begin
      full = int'(ta) + int'(tb) + int'(tc);
      sres = sa + sb + int'(tc);
    end
    ovf = (sres > 127) || (sres < -128);
    s8  = full[W-1:0];
    co  = full[W];
    return {ovf, co, s8};
  endfunction

  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts, input logic [W-1:0] es,
                        input logic ec, input logic eo, input int hold, input bit chk_lat);
    int n;
    int k;
    @(negedge clk);
    a = ta; b = tb; c_in = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = ~ta; b = W'($urandom); c_in = ~tc; sub = ~ts;
    k = 0;
    while (k < 100) begin
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom);
      @(posedge clk);
      k++;
      @(negedge clk);
      if (out_valid) break;
    end
    in_valid = 1'b0;
    // k edges to register out_valid; the consumer first samples it high at edge k+1
    if (chk_lat) check({nm, "_valid_latency"}, 32'(k + 1), 32'(W + 1));
    check({nm, "_result"}, {21'd0, out_valid, in_ready, busy, sum, c_out, overflow},
          {21'd0, 1'b1, 1'b0, 1'b1, es, ec, eo});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({nm, "_hold"}, {21'd0, out_valid, in_ready, busy, sum, c_out, overflow},
            {21'd0, 1'b1, 1'b0, 1'b1, es, ec, eo});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, "_after_handshake"}, {21'd0, out_valid, in_ready, busy, sum, c_out, overflow},
          {21'd0, 1'b0, 1'b1, 1'b0, es, ec, eo});
  endtask

  initial begin
    logic [W+1:0]  m;
    logic [W-1:0]  ra;
    logic [W-1:0]  rb;
    logic          rc;
    logic          rs;
    logic [W+1:0]  exp_q[$];
    logic [W+1:0]  e;
    int            n;
    int            sent;
    int            got;
    int            cyc;
    int            last_acc;
    bit            accepting;
    bit            saw_valid;

    vecs.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h0F, 8'h10, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0});
    vecs.push_back('{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {21'd0, out_valid, in_ready, busy, sum, c_out, overflow},
          {21'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    rst = 1'b0;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].vs,
             vecs[i].es, vecs[i].ec, vecs[i].eo, (i == 0) ? 5 : 0, 1'b1);

    // Reset during the 4th RUN cycle must discard the operation.
    @(negedge clk);
    a = 8'h55; b = 8'h33; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_mid_run", {21'd0, out_valid, in_ready, busy, sum, c_out, overflow},
          {21'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    saw_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("no_output_after_abort", {31'd0, saw_valid}, 32'd0);
    run_op("post_abort", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      m = model(ra, rb, rc, rs);
      run_op($sformatf("rand%0d", i), ra, rb, rc, rs, m[W-1:0], m[W], m[W+1], 1, 1'b0);
    end

    // Back-to-back: in_valid and out_ready held high.
    sent = 0; got = 0; cyc = 0; last_acc = -1;
    out_ready = 1'b1;
    for (n = 0; n < 400 && got < 20; n++) begin
      @(negedge clk);
      accepting = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("b2b_unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("b2b_result%0d", got), {22'd0, overflow, c_out, sum}, {22'd0, e});
        end
        got++;
      end
      if (in_ready) begin
        if (sent < 20) begin
          ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
          a = ra; b = rb; c_in = rc; sub = rs; in_valid = 1'b1;
          exp_q.push_back(model(ra, rb, rc, rs));
          sent++;
          accepting = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(posedge clk);
      cyc++;
      if (accepting) begin
        if (last_acc >= 0) check("b2b_accept_spacing", 32'(cyc - last_acc), 32'(W + 2));
        last_acc = cyc;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_result_count", 32'(got), 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
